shift_frame_receiver: RTL and testbench

- Serial-to-parallel receiver; the receiving end of the LSB-first serial link driven by the team's universal shift register in shift-right mode.
- Detects a start bit, shifts in WIDTH data bits, checks the stop bit and presents the word on a parallel bus.
- Parallel word is held with a Valid/Ack handshake; framing and overrun errors are flagged.

---
 rtl/shift_frame_receiver.sv | 124 ++++++++++++
 tb/tb_shift_frame_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_receiver.sv
// Serial-to-parallel frame receiver for an LSB-first link.
// Frame: start bit (0), WIDTH data bits LSB first, stop bit (1).
// The received word is held on D_par under a Valid/Ack handshake.
// Framing and overrun errors are kept in sticky flags.
module shift_frame_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             Serial_in,
  input  logic             Bit_en,
  input  logic             Ack,
  input  logic             Err_clr,
  output logic [WIDTH-1:0] D_par,
  output logic             Valid,
  output logic             Busy,
  output logic             Frame_err,
  output logic             Overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] d_par_q, d_par_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // Next-state, datapath and handshake/error-flag logic; strobed sampling only on Bit_en.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    d_par_d     = d_par_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (Ack) begin
      valid_d = 1'b0;
    end
    if (Err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (Bit_en) begin
      case (state_q)
        IDLE: begin
          if (!Serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {Serial_in, shreg_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          state_d = IDLE;
          if (Serial_in) begin
            if (!valid_q || Ack) begin
              d_par_d = shreg_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      d_par_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      d_par_q     <= d_par_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign D_par     = d_par_q;
  assign Valid     = valid_q;
  assign Busy      = busy_q;
  assign Frame_err = frame_err_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_shift_frame_receiver.sv
// Testbench for shift_frame_receiver (WIDTH=4): directed frames with literal
// expectations plus randomized line activity against a frame-level model.
module tb_shift_frame_receiver;

  localparam int WIDTH = 4;

  logic             CLK;
  logic             Clear;
  logic             Serial_in;
  logic             Bit_en;
  logic             Ack;
  logic             Err_clr;
  logic [WIDTH-1:0] D_par;
  logic             Valid;
  logic             Busy;
  logic             Frame_err;
  logic             Overrun;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: number of line bits collected in the current frame
  // (0 = waiting for start) and the data value accumulated arithmetically.
  int               mLen   = 0;
  int               mAcc   = 0;
  logic [WIDTH-1:0] mDpar  = '0;
  logic             mValid = 1'b0;
  logic             mBusy  = 1'b0;
  logic             mFerr  = 1'b0;
  logic             mOvr   = 1'b0;

  shift_frame_receiver #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .Clear     (Clear),
    .Serial_in (Serial_in),
    .Bit_en    (Bit_en),
    .Ack       (Ack),
    .Err_clr   (Err_clr),
    .D_par     (D_par),
    .Valid     (Valid),
    .Busy      (Busy),
    .Frame_err (Frame_err),
    .Overrun   (Overrun)
  );

  // 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    bit stopSeen;
    bit stopGood;
    stopSeen = 0;
    stopGood = 0;
    if (Bit_en) begin
      if (mLen == 0) begin
        if (!Serial_in) begin
          mLen = 1;
          mAcc = 0;
        end
      end else if (mLen <= WIDTH) begin
        mAcc = mAcc + (int'(Serial_in) << (mLen - 1));
        mLen = mLen + 1;
      end else begin
        stopSeen = 1;
        stopGood = Serial_in;
        mLen = 0;
      end
    end
    if (Err_clr) begin
      mFerr = 1'b0;
      mOvr  = 1'b0;
    end
    if (stopSeen && stopGood) begin
      if (!mValid || Ack) begin
        mDpar  = WIDTH'(mAcc);
        mValid = 1'b1;
      end else begin
        mOvr = 1'b1;
        if (Ack) mValid = 1'b0;
      end
    end else begin
      if (Ack) mValid = 1'b0;
      if (stopSeen) mFerr = 1'b1;
    end
    mBusy = (mLen != 0);
  endtask

  // Model process: async reset on Clear, otherwise step on each rising edge.
  initial begin
    forever begin
      @(posedge CLK or negedge Clear);
      if (!Clear) begin
        mLen = 0; mAcc = 0; mDpar = '0;
        mValid = 1'b0; mBusy = 1'b0; mFerr = 1'b0; mOvr = 1'b0;
      end else begin
        modelStep();
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge CLK);
      checkOutput("cyc_D_par", 32'(D_par), 32'(mDpar));
      checkOutput("cyc_Valid", 32'(Valid), 32'(mValid));
      checkOutput("cyc_Busy", 32'(Busy), 32'(mBusy));
      checkOutput("cyc_Frame_err", 32'(Frame_err), 32'(mFerr));
      checkOutput("cyc_Overrun", 32'(Overrun), 32'(mOvr));
    end
  end

  // Drive one cycle of inputs (called at posedge+2), let the edge happen, return at posedge+2.
  task automatic applyStimulus(input logic sin, input logic be, input logic ack, input logic eclr);
    Serial_in = sin;
    Bit_en    = be;
    Ack       = ack;
    Err_clr   = eclr;
    @(posedge CLK);
    #2;
  endtask

  task automatic idleInputs();
    Serial_in = 1'b1;
    Bit_en    = 1'b0;
    Ack       = 1'b0;
    Err_clr   = 1'b0;
  endtask

  // Send start, WIDTH data bits LSB first and the stop bit; optional idle gap
  // strobes between bits and optional Ack on the stop edge.
  task automatic sendWord(input logic [WIDTH-1:0] d, input logic stopBit, input int gap, input logic ackOnStop);
    logic b;
    for (int i = 0; i < WIDTH + 2; i++) begin
      if (i == 0) b = 1'b0;
      else if (i == WIDTH + 1) b = stopBit;
      else b = d[i-1];
      applyStimulus(b, 1'b1, (i == WIDTH + 1) ? ackOnStop : 1'b0, 1'b0);
      if (i < WIDTH + 1) begin
        for (int g = 0; g < gap; g++) applyStimulus(b, 1'b0, 1'b0, 1'b0);
      end
    end
    idleInputs();
  endtask

  initial begin
    Clear = 1'b1;
    idleInputs();
    #1 Clear = 1'b0;

    // Reset state.
    @(posedge CLK);
    @(posedge CLK);
    #2;
    checkOutput("rst_D_par", 32'(D_par), 32'h0);
    checkOutput("rst_Valid", 32'(Valid), 32'h0);
    checkOutput("rst_Busy", 32'(Busy), 32'h0);
    checkOutput("rst_Frame_err", 32'(Frame_err), 32'h0);
    checkOutput("rst_Overrun", 32'(Overrun), 32'h0);
    Clear = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_Busy", 32'(Busy), 32'h0);
    checkOutput("idle_Valid", 32'(Valid), 32'h0);

    // Good frame 0x6 then Ack.
    sendWord(4'h6, 1'b1, 0, 1'b0);
    checkOutput("good_D_par", 32'(D_par), 32'h6);
    checkOutput("good_Valid", 32'(Valid), 32'h1);
    checkOutput("good_Busy", 32'(Busy), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleInputs();
    checkOutput("ack_Valid", 32'(Valid), 32'h0);
    checkOutput("ack_D_par", 32'(D_par), 32'h6);

    // Gapped strobe frame 0xD.
    sendWord(4'hD, 1'b1, 1, 1'b0);
    checkOutput("gap_D_par", 32'(D_par), 32'hD);
    checkOutput("gap_Valid", 32'(Valid), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleInputs();

    // Framing error, then clear it.
    sendWord(4'hF, 1'b0, 0, 1'b0);
    checkOutput("ferr_Frame_err", 32'(Frame_err), 32'h1);
    checkOutput("ferr_Valid", 32'(Valid), 32'h0);
    checkOutput("ferr_D_par", 32'(D_par), 32'hD);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idleInputs();
    checkOutput("eclr_Frame_err", 32'(Frame_err), 32'h0);

    // Overrun, then same-edge Ack on completion.
    sendWord(4'h6, 1'b1, 0, 1'b0);
    sendWord(4'h9, 1'b1, 0, 1'b0);
    checkOutput("ovr_D_par", 32'(D_par), 32'h6);
    checkOutput("ovr_Overrun", 32'(Overrun), 32'h1);
    checkOutput("ovr_Valid", 32'(Valid), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idleInputs();
    checkOutput("ovr_clr", 32'(Overrun), 32'h0);
    sendWord(4'h9, 1'b1, 0, 1'b1);
    checkOutput("sameack_D_par", 32'(D_par), 32'h9);
    checkOutput("sameack_Valid", 32'(Valid), 32'h1);
    checkOutput("sameack_Overrun", 32'(Overrun), 32'h0);

    // Mid-frame reset after two data bits.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idleInputs();
    checkOutput("mid_Busy_before", 32'(Busy), 32'h1);
    #1 Clear = 1'b0;
    #1;
    checkOutput("mid_Busy", 32'(Busy), 32'h0);
    checkOutput("mid_D_par", 32'(D_par), 32'h0);
    checkOutput("mid_Valid", 32'(Valid), 32'h0);
    @(posedge CLK);
    #2 Clear = 1'b1;
    sendWord(4'hA, 1'b1, 0, 1'b0);
    checkOutput("after_D_par", 32'(D_par), 32'hA);
    checkOutput("after_Valid", 32'(Valid), 32'h1);

    // Randomized line activity checked by the model on every cycle.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(logic'($urandom_range(0, 9) < 6),
                    logic'($urandom_range(0, 9) < 7),
                    logic'($urandom_range(0, 9) < 2),
                    logic'($urandom_range(0, 9) < 1));
    end
    idleInputs();
    for (int i = 0; i < 10; i++) begin
      sendWord(WIDTH'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0),
               $urandom_range(0, 2), logic'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge CLK);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
